fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
- Instruction prefetch stage between the word-addressed synchronous memory port and instruction decode.
- Issues sequential word reads, accounting for the memory's 1-cycle registered read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Redirects (taken branch, jump, trap) flush the buffer and discard any in-flight read.

Parameters:
- M_WIDTH, 32, memory data / instruction word width in bits.
- ADDR_W, 30, memory word-address width; PC width is ADDR_W+2.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] are ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  word address of the read being issued.
- mem_req  out  1  read issued this cycle; data returns on mem_data in the next cycle.
- mem_grant  in  1  memory port free for fetch this cycle; the load/store unit has priority.
- mem_data  in  M_WIDTH  read data, valid the cycle after an accepted request.
- redirect  in  1  flush request, single-cycle pulse.
- redirect_pc  in  ADDR_W+2  new byte PC; bits [1:0] are ignored.
- instr_valid  out  1  instr and instr_pc hold a valid entry.
- instr  out  M_WIDTH  head instruction word.
- instr_pc  out  ADDR_W+2  byte PC of the head instruction; bits [1:0] are always 0.
- instr_ready  in  1  decode accepts the head entry this cycle.

Behaviour:
- Reset (async assert, any time, including mid-read):
  - count=0, inflight=0, fetch_pc=RESET_PC[ADDR_W+1:2].
  - instr_valid=0, mem_req=0, instr=0, instr_pc=0.
  - An in-flight read is forgotten.
- Issue:
  - mem_req = mem_grant & ~redirect & (count+inflight < DEPTH).
  - mem_addr = fetch_pc.
  - On an issue edge: fetch_pc increments by 1, wrapping at 2^ADDR_W to 0; inflight is set to 1.
- Return:
  - In the cycle after an issue, mem_data is written at the tail with tag {fetch_pc_at_issue,2'b00}.
  - Default latency: request in cycle N, data on mem_data in cycle N+1, instr_valid high in cycle N+2.
  - Back-to-back issue every cycle is allowed; throughput is 1 word per cycle when granted and not full.
- Pop:
  - An entry is consumed on any edge where instr_valid & instr_ready.
  - Head pointer advances modulo DEPTH.
  - instr and instr_pc are held stable while instr_valid & ~instr_ready.
- Full:
  - The count+inflight bound guarantees a returning word always has a slot; no data is dropped.
  - Return and pop in the same cycle with count==DEPTH-1 is legal; count is unchanged.
- Empty: instr_valid=0; instr and instr_pc hold their last values (don't-care).
- Redirect (edge with redirect=1):
  - count←0, head=tail←0.
  - A returning word in that same cycle is discarded.
  - inflight←0, and any word returning in the next cycle is discarded.
  - fetch_pc←redirect_pc[ADDR_W+1:2]; no issue in the redirect cycle.
  - A simultaneous pop is ignored; redirect wins.
  - The first new request is issued in the cycle after redirect, if granted.
- mem_grant=0: no issue; already in-flight data is still captured.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the FIFO is empty and a valid (non-discarded) word returns, it is presented combinationally on instr/instr_pc with instr_valid=1 in cycle N+1.
  - If instr_ready is high it is consumed without being written.
  - Otherwise it is written to the FIFO as normal.
  - Fetch-to-decode latency becomes 1 cycle.
- Undefined: no combinational path from mem_data to outputs; latency is 2 cycles as above.

Decomposition:
- Shared package: instruction width constant (32) and reset PC default.
- Sub-module: prefetch_fifo (DEPTH x {PC, instr} storage, head/tail/count, push/pop/flush).
- fetch_prefetch holds fetch_pc, the inflight/discard flag and issue logic.

Test Plan:
- Reset release with RESET_PC=0, grant=1, ready=1, memory word k = 32'hA000_0000+k -> mem_addr 0,1,2,… on consecutive cycles; instr_valid from cycle 2 with instr 32'hA000_0000 at instr_pc 0, then instr_pc 4, 8, … one per cycle.
- ready=0 with grant=1 -> exactly DEPTH=8 requests issued (addresses 0..7), then mem_req=0; after ready=1, 8 entries drain in order (PC 0..28) and issue resumes at address 8.
- Redirect to 32'h0000_0103 in the cycle after an issue to address 5 -> returning word 5 discarded, next mem_addr=30'h40, first decoded instr_pc=32'h100, no stale entries.
- Redirect with instr_valid&ready in the same cycle and FIFO holding 3 entries -> FIFO empties, none of the 3 entries is popped, instr_valid=0 for 2 cycles (1 cycle with PREFETCH_BYPASS_EN).
- mem_grant toggling 1,0,1,0 -> requests only on granted cycles, instruction stream contiguous with no gaps in PC; rst asserted mid-stream -> instr_valid=0 immediately, fetch restarts at RESET_PC.
- fetch_pc=30'h3FFF_FFFF issued -> next mem_addr=0, instr_pc sequence 32'hFFFF_FFFC then 32'h0000_0000.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared constants for the instruction prefetch stage: instruction width and reset PC.
package fetch_prefetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Circular buffer of {word PC, instruction} pairs with flush.
// The head entry is presented directly from storage so decode sees it without a read stage.
module prefetch_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [DATA_W-1:0]        head_data,
  output logic [PC_W-1:0]          head_pc
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [PC_W-1:0]   pc_d   [DEPTH];

  // Flush has priority over any push or pop in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        data_d[tail_q] = push_data;
        pc_d[tail_q]   = push_pc;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign head_data = data_q[head_q];
  assign head_pc   = pc_q[head_q];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch: sequential reads from a 1-cycle-latency memory into a FIFO feeding decode.
// Define PREFETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int               M_WIDTH  = INSTR_W,
  parameter int               ADDR_W   = 30,
  parameter int               DEPTH    = 8,
  parameter logic [ADDR_W+1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_req,
  input  logic                mem_grant,
  input  logic [M_WIDTH-1:0]  mem_data,
  input  logic                redirect,
  input  logic [ADDR_W+1:0]   redirect_pc,
  output logic                instr_valid,
  output logic [M_WIDTH-1:0]  instr,
  output logic [ADDR_W+1:0]   instr_pc,
  input  logic                instr_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  issue_pc_q, issue_pc_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   occupancy;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               issue;
  logic               ret_valid;
  logic [M_WIDTH-1:0] head_data;
  logic [ADDR_W-1:0]  head_pc;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Reserving a slot for the in-flight word means a returning word can never find the FIFO full.
  assign occupancy = fifo_count + CNT_W'(inflight_q);
  assign issue     = rst & mem_grant & ~redirect & (occupancy < CNT_W'(DEPTH));
  assign ret_valid = inflight_q & ~redirect;
  assign mem_req   = issue;
  assign mem_addr  = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc[ADDR_W+1:2];
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      issue_pc_d = fetch_pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC[ADDR_W+1:2];
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef PREFETCH_BYPASS_EN
  logic bypass;

  // A word consumed straight off the bus is never written into the FIFO.
  assign bypass      = fifo_empty & ret_valid;
  assign instr_valid = ~fifo_empty | bypass;
  assign instr       = bypass ? mem_data : head_data;
  assign instr_pc    = {(bypass ? issue_pc_q : head_pc), 2'b00};
  assign fifo_push   = ret_valid & ~(bypass & instr_ready);
`else
  assign instr_valid = ~fifo_empty;
  assign instr       = head_data;
  assign instr_pc    = {head_pc, 2'b00};
  assign fifo_push   = ret_valid;
`endif

  assign fifo_pop = ~fifo_empty & instr_ready & ~redirect;

  prefetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (M_WIDTH),
    .PC_W   (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_data),
    .push_pc   (issue_pc_q),
    .pop       (fifo_pop),
    .flush     (redirect),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_data (head_data),
    .head_pc   (head_pc)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed self-checking bench for fetch_prefetch with a 1-cycle registered memory model.
// Latency expectations follow PREFETCH_BYPASS_EN when it is defined for the build.
module tb_fetch_prefetch;

  localparam int M_WIDTH = 32;
  localparam int ADDR_W  = 30;
  localparam int DEPTH   = 8;
`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_grant;
  logic [M_WIDTH-1:0] mem_data;
  logic              redirect;
  logic [ADDR_W+1:0] redirect_pc;
  logic              instr_valid;
  logic [M_WIDTH-1:0] instr;
  logic [ADDR_W+1:0] instr_pc;
  logic              instr_ready;

  int checks = 0;
  int errors = 0;

  fetch_prefetch #(
    .M_WIDTH  (M_WIDTH),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word k holds 32'hA000_0000 + k, returned one cycle after the request.
  always @(posedge clk) begin
    if (mem_req) mem_data <= 32'hA000_0000 + {2'b00, mem_addr};
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 with reset released.
  task automatic restart(input logic grant, input logic ready);
    rst         = 1'b0;
    mem_grant   = grant;
    instr_ready = ready;
    redirect    = 1'b0;
    redirect_pc = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    mem_grant   = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    next_cycle();
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req);
    end
    checks++;
    if (instr !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instr);
    end
    checks++;
    if (instr_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc: got %h expected 00000000", instr_pc);
    end
  endtask

  task automatic test_stream();
    restart(1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 30'(c)) begin
        errors++; $display("[TB] FAIL stream_issue c=%0d: got req=%b addr=%h expected req=1 addr=%h",
                           c, mem_req, mem_addr, 30'(c));
      end
      if (c < LAT) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL stream_early_valid c=%0d: got %b expected 0", c, instr_valid);
        end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'((c - LAT) * 4) ||
            instr !== 32'hA000_0000 + 32'(c - LAT)) begin
          errors++; $display("[TB] FAIL stream_out c=%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                             c, instr_valid, instr_pc, instr, 32'((c - LAT) * 4),
                             32'hA000_0000 + 32'(c - LAT));
        end
      end
    end
  endtask

  task automatic test_full();
    int          nreq;
    logic [29:0] exp_addr;
    logic [31:0] exp_pc;
    logic        resumed;
    nreq     = 0;
    exp_addr = '0;
    restart(1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (mem_req) begin
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++; $display("[TB] FAIL full_addr: got %h expected %h", mem_addr, exp_addr);
        end
        exp_addr++;
        nreq++;
      end
    end
    checks++;
    if (nreq != DEPTH) begin
      errors++; $display("[TB] FAIL full_req_count: got %0d expected %0d", nreq, DEPTH);
    end
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL full_hold: got req=%b v=%b pc=%h expected req=0 v=1 pc=00000000",
                         mem_req, instr_valid, instr_pc);
    end
    next_cycle();
    instr_ready = 1'b1;
    exp_pc  = 32'h0;
    resumed = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (instr_valid && exp_pc < 32'd40) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== 32'hA000_0000 + (exp_pc >> 2)) begin
          errors++; $display("[TB] FAIL drain_order: got pc=%h i=%h expected pc=%h i=%h",
                             instr_pc, instr, exp_pc, 32'hA000_0000 + (exp_pc >> 2));
        end
        exp_pc += 32'd4;
      end
      if (mem_req && !resumed) begin
        resumed = 1'b1;
        checks++;
        if (mem_addr !== 30'd8) begin
          errors++; $display("[TB] FAIL full_resume_addr: got %h expected 00000008", mem_addr);
        end
      end
    end
    checks++;
    if (exp_pc !== 32'd40 || !resumed) begin
      errors++; $display("[TB] FAIL drain_progress: got last_pc=%h resumed=%b expected 00000028 1",
                         exp_pc, resumed);
    end
  endtask

  task automatic test_redirect();
    logic        found;
    logic [31:0] exp_pc;
    found = 1'b0;
    restart(1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (mem_req && mem_addr == 30'd6) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL redirect_setup: got no issue to 6 expected one within 20 cycles");
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL redirect_no_issue: got %b expected 0", mem_req);
    end
    next_cycle();
    redirect = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h40 || instr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL redirect_target: got req=%b addr=%h v=%b expected req=1 addr=00000040 v=0",
                         mem_req, mem_addr, instr_valid);
    end
    exp_pc = 32'h100;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      #1;
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== 32'hA000_0000 + (exp_pc >> 2)) begin
          errors++; $display("[TB] FAIL redirect_stream: got pc=%h i=%h expected pc=%h i=%h",
                             instr_pc, instr, exp_pc, 32'hA000_0000 + (exp_pc >> 2));
        end
        exp_pc += 32'd4;
      end
    end
    checks++;
    if (exp_pc == 32'h100) begin
      errors++; $display("[TB] FAIL redirect_progress: got pc=%h expected beyond 00000100", exp_pc);
    end
  endtask

  task automatic test_redirect_pop();
    restart(1'b1, 1'b0);
    #1;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_grant = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL rpop_nogrant: got %b expected 0", mem_req);
    end
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL rpop_setup: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc);
    end
    mem_grant   = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL rpop_no_issue: got %b expected 0", mem_req);
    end
    next_cycle();
    redirect = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 30'h80) begin
      errors++; $display("[TB] FAIL rpop_flushed: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000080",
                         instr_valid, mem_req, mem_addr);
    end
    for (int k = 2; k <= LAT; k++) begin
      next_cycle();
      #1;
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rpop_gap k=%0d: got %b expected 0", k, instr_valid);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'hA000_0080) begin
      errors++; $display("[TB] FAIL rpop_first: got v=%b pc=%h i=%h expected v=1 pc=00000200 i=a0000080",
                         instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_grant_toggle();
    logic [29:0] exp_addr;
    logic [31:0] exp_pc;
    exp_addr = '0;
    exp_pc   = '0;
    restart(1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        next_cycle();
        mem_grant = (c % 2 == 0);
      end
      #1;
      checks++;
      if (mem_req !== mem_grant) begin
        errors++; $display("[TB] FAIL toggle_req c=%0d: got %b expected %b", c, mem_req, mem_grant);
      end
      if (mem_req) begin
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++; $display("[TB] FAIL toggle_addr: got %h expected %h", mem_addr, exp_addr);
        end
        exp_addr++;
      end
      if (instr_valid) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== 32'hA000_0000 + (exp_pc >> 2)) begin
          errors++; $display("[TB] FAIL toggle_stream: got pc=%h i=%h expected pc=%h i=%h",
                             instr_pc, instr, exp_pc, 32'hA000_0000 + (exp_pc >> 2));
        end
        exp_pc += 32'd4;
      end
    end
    checks++;
    if (exp_pc < 32'd24) begin
      errors++; $display("[TB] FAIL toggle_progress: got pc=%h expected at least 00000018", exp_pc);
    end
    next_cycle();
    mem_grant = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_pre: got %b expected 1", instr_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_now: got v=%b req=%b expected v=0 req=0", instr_valid, mem_req);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h0) begin
      errors++; $display("[TB] FAIL midreset_restart: got req=%b addr=%h expected req=1 addr=00000000",
                         mem_req, mem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pcs [3];
    logic [31:0] exp_ins [3];
    int          idx;
    exp_pcs = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_ins = '{32'hDFFF_FFFF, 32'hA000_0000, 32'hA000_0001};
    idx = 0;
    restart(1'b1, 1'b1);
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h3FFF_FFFF) begin
      errors++; $display("[TB] FAIL wrap_top: got req=%b addr=%h expected req=1 addr=3fffffff", mem_req, mem_addr);
    end
    next_cycle();
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h0) begin
      errors++; $display("[TB] FAIL wrap_zero: got req=%b addr=%h expected req=1 addr=00000000", mem_req, mem_addr);
    end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (instr_valid && idx < 3) begin
        checks++;
        if (instr_pc !== exp_pcs[idx] || instr !== exp_ins[idx]) begin
          errors++; $display("[TB] FAIL wrap_stream idx=%0d: got pc=%h i=%h expected pc=%h i=%h",
                             idx, instr_pc, instr, exp_pcs[idx], exp_ins[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 3) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d expected 3", idx);
    end
  endtask

  initial begin
    rst         = 1'b1;
    mem_grant   = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_data    = '0;
    #2;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_pop();
    test_grant_toggle();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
